// File: rtl/clint.sv
// Core-local interruptor: turns ECALL/EBREAK/timer IRQ/MRET into CSR write
// sequences on the register-file port followed by a one-cycle PC redirect.
module clint (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        irq_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        clint_wr_en_o,
  output logic [31:0] clint_wr_addr_o,
  output logic [31:0] clint_wr_data_o,
  output logic        hold_flag_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] INST_ECALL   = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] INST_MRET    = 32'h3020_0073;
  localparam logic [31:0] CSR_MSTATUS  = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC     = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE   = 32'h0000_0342;
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    W_MRET,
    ASSERT
  } state_t;

  state_t      state;
  logic [31:0] mepc_q;
  logic [31:0] cause_q;
  logic        ret_q;

  logic        is_ecall;
  logic        is_ebreak;
  logic        is_irq;
  logic        is_mret;
  logic        take_trap;
  logic [31:0] mepc_nxt;
  logic [31:0] cause_nxt;
  logic [31:0] trap_status;
  logic [31:0] mret_status;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_irq    = irq_i & csr_mstatus_i[3];
  assign is_mret   = (inst_i == INST_MRET);
  assign take_trap = is_ecall | is_ebreak | is_irq;

  // Trap entry pushes MIE into MPIE and masks; return pops MPIE back into MIE.
  assign trap_status = {csr_mstatus_i[31:8], csr_mstatus_i[3], csr_mstatus_i[6:4],
                        1'b0, csr_mstatus_i[2:0]};
  assign mret_status = {csr_mstatus_i[31:8], 1'b1, csr_mstatus_i[6:4],
                        csr_mstatus_i[7], csr_mstatus_i[2:0]};

  // Exceptions win over the interrupt; an interrupt returns to the jump target if taken.
  always_comb begin
    mepc_nxt  = inst_addr_i;
    cause_nxt = CAUSE_TIMER;
    if (is_ecall) begin
      cause_nxt = CAUSE_ECALL;
    end else if (is_ebreak) begin
      cause_nxt = CAUSE_EBREAK;
    end else if (jump_flag_i) begin
      mepc_nxt = jump_addr_i;
    end
  end

  // Stall is raised in the detection cycle itself so decode does not advance.
  assign hold_flag_o = (state == IDLE) ? (take_trap | is_mret) : (state != ASSERT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      mepc_q          <= '0;
      cause_q         <= '0;
      ret_q           <= 1'b0;
      clint_wr_en_o   <= 1'b0;
      clint_wr_addr_o <= '0;
      clint_wr_data_o <= '0;
      int_assert_o    <= 1'b0;
      int_addr_o      <= '0;
    end else begin
      clint_wr_en_o   <= 1'b0;
      clint_wr_addr_o <= '0;
      clint_wr_data_o <= '0;
      int_assert_o    <= 1'b0;
      int_addr_o      <= '0;
      case (state)
        IDLE: begin
          if (take_trap) begin
            state           <= W_MEPC;
            mepc_q          <= mepc_nxt;
            cause_q         <= cause_nxt;
            ret_q           <= 1'b0;
            clint_wr_en_o   <= 1'b1;
            clint_wr_addr_o <= CSR_MEPC;
            clint_wr_data_o <= mepc_nxt;
          end else if (is_mret) begin
            state           <= W_MRET;
            ret_q           <= 1'b1;
            clint_wr_en_o   <= 1'b1;
            clint_wr_addr_o <= CSR_MSTATUS;
            clint_wr_data_o <= mret_status;
          end
        end
        W_MEPC: begin
          state           <= W_MCAUSE;
          clint_wr_en_o   <= 1'b1;
          clint_wr_addr_o <= CSR_MCAUSE;
          clint_wr_data_o <= cause_q;
        end
        W_MCAUSE: begin
          state           <= W_MSTATUS;
          clint_wr_en_o   <= 1'b1;
          clint_wr_addr_o <= CSR_MSTATUS;
          clint_wr_data_o <= trap_status;
        end
        W_MSTATUS, W_MRET: begin
          state        <= ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= ret_q ? csr_mepc_i : csr_mtvec_i;
        end
        ASSERT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
